// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: datapath width, ALU encodings, forwarding
// selects and the ID/EX pipeline register layout.
package rv32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_AUIPC = 4'b1000,
        ALU_LUI   = 4'b1001,
        ALU_SLL   = 4'b1010,
        ALU_SRA   = 4'b1011,
        ALU_SRL   = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // All-zero value of this record is the bubble.
    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_control;
        logic [2:0]      funct3;
        logic [1:0]      alu_op;
        logic            src_a_pc;
        logic            src_b_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

endpackage

// File: rtl/operand_forward.sv
// Per-operand bypass select: MEM producer beats WB producer beats the
// register-file value; x0 is never a source.
module operand_forward
    import rv32_pkg::*;
(
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] reg_val,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_val,
    output logic [1:0]      sel
);

    always_comb begin
        sel     = FWD_REG;
        fwd_val = reg_val;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) begin
            sel     = FWD_MEM;
            fwd_val = mem_result;
        end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) begin
            sel     = FWD_WB;
            fwd_val = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stall.
// ID_EX_FORWARDING_EN selects bypassing + load-use stall; without it, stall until writers retire.
module id_ex_stage
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [3:0]      id_alu_control,
    input  logic [2:0]      id_funct3,
    input  logic [1:0]      id_alu_op,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_control,
    output logic [2:0]      ex_funct3,
    output logic [1:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write
);

    id_ex_t          stage_p0;
    id_ex_t          stage_p1;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [1:0]      sel_rs1;
    logic [1:0]      sel_rs2;

    // p0: what the register loads next; any kill condition yields a bubble
    always_comb begin
        stage_p0 = '0;
        if (!(flush || id_stall || !id_valid)) begin
            stage_p0.vld         = 1'b1;
            stage_p0.pc          = id_pc;
            stage_p0.rs1_data    = id_rs1_data;
            stage_p0.rs2_data    = id_rs2_data;
            stage_p0.imm         = id_imm;
            stage_p0.rs1         = id_rs1;
            stage_p0.rs2         = id_rs2;
            stage_p0.rd          = id_rd;
            stage_p0.alu_control = id_alu_control;
            stage_p0.funct3      = id_funct3;
            stage_p0.alu_op      = id_alu_op;
            stage_p0.src_a_pc    = id_src_a_pc;
            stage_p0.src_b_imm   = id_src_b_imm;
            stage_p0.reg_write   = id_reg_write;
            stage_p0.mem_read    = id_mem_read;
            stage_p0.mem_write   = id_mem_write;
        end
    end

    // p1: the ID/EX register itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_p1 <= '0;
        else
            stage_p1 <= stage_p0;
    end

`ifdef ID_EX_FORWARDING_EN
    logic unused_sel;

    operand_forward u_fwd_rs1 (
        .rs(stage_p1.rs1), .reg_val(stage_p1.rs1_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .fwd_val(fwd_rs1), .sel(sel_rs1)
    );

    operand_forward u_fwd_rs2 (
        .rs(stage_p1.rs2), .reg_val(stage_p1.rs2_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .fwd_val(fwd_rs2), .sel(sel_rs2)
    );

    assign unused_sel = ^{sel_rs1, sel_rs2};

    // Only a load in EX cannot be bypassed in time.
    assign id_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
`else
    logic [XLEN-1:0] unused_fwd_rs1;
    logic [XLEN-1:0] unused_fwd_rs2;
    logic            unused_ok;
    logic            ex_hit_rs1;
    logic            ex_hit_rs2;

    // Same matching rule, applied to ID's sources to find pending MEM/WB writers.
    operand_forward u_hz_rs1 (
        .rs(id_rs1), .reg_val(id_rs1_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .fwd_val(unused_fwd_rs1), .sel(sel_rs1)
    );

    operand_forward u_hz_rs2 (
        .rs(id_rs2), .reg_val(id_rs2_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .fwd_val(unused_fwd_rs2), .sel(sel_rs2)
    );

    assign ex_hit_rs1 = ex_valid && ex_reg_write && ex_rd != 5'd0 && ex_rd == id_rs1;
    assign ex_hit_rs2 = ex_valid && ex_reg_write && ex_rd != 5'd0 && ex_rd == id_rs2;

    assign id_stall = id_valid &&
                      ((id_use_rs1 && (ex_hit_rs1 || sel_rs1 != FWD_REG)) ||
                       (id_use_rs2 && (ex_hit_rs2 || sel_rs2 != FWD_REG)));

    assign fwd_rs1   = stage_p1.rs1_data;
    assign fwd_rs2   = stage_p1.rs2_data;
    assign unused_ok = ^{stage_p1.rs1, stage_p1.rs2, unused_fwd_rs1, unused_fwd_rs2};
`endif

    assign ex_valid       = stage_p1.vld;
    assign ex_pc          = stage_p1.pc;
    assign ex_rd          = stage_p1.rd;
    assign ex_a           = stage_p1.src_a_pc  ? stage_p1.pc  : fwd_rs1;
    assign ex_b           = stage_p1.src_b_imm ? stage_p1.imm : fwd_rs2;
    assign ex_store_data  = fwd_rs2;
    assign ex_alu_control = stage_p1.alu_control;
    assign ex_funct3      = stage_p1.funct3;
    assign ex_alu_op      = stage_p1.alu_op;
    assign ex_reg_write   = stage_p1.reg_write;
    assign ex_mem_read    = stage_p1.mem_read;
    assign ex_mem_write   = stage_p1.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_src_a_pc, id_src_b_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_control;
    logic [2:0]  id_funct3;
    logic [1:0]  id_alu_op;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_control;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_alu_op;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_alu_control(id_alu_control), .id_funct3(id_funct3), .id_alu_op(id_alu_op),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
        .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    // Model of the instruction sitting in EX; all-zero means bubble.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  ac;
        logic [2:0]  f3;
        logic [1:0]  op;
        logic        sa, sb, rw, mr, mw;
    } mrec_t;

    mrec_t m, nxt;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] v);
        if (FWD_EN && mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return mem_result;
        if (FWD_EN && wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return wb_result;
        return v;
    endfunction

    function automatic logic writer_pending(input logic [4:0] r);
        return r != 5'd0 && ((m.v && m.rw && m.rd == r) ||
                             (mem_reg_write && mem_rd == r) || (wb_reg_write && wb_rd == r));
    endfunction

    function automatic logic model_stall();
        if (FWD_EN)
            return id_valid && m.v && m.mr && m.rd != 5'd0 &&
                   ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
        return id_valid && ((id_use_rs1 && writer_pending(id_rs1)) ||
                            (id_use_rs2 && writer_pending(id_rs2)));
    endfunction

    task automatic compare();
        logic stall_e;
        stall_e = model_stall();
        chk("id_stall", 32'(id_stall), 32'(stall_e));
        chk("ex_valid", 32'(ex_valid), 32'(m.v));
        chk("ex_pc", ex_pc, m.pc);
        chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        chk("ex_a", ex_a, m.sa ? m.pc : model_fwd(m.rs1, m.rs1d));
        chk("ex_b", ex_b, m.sb ? m.imm : model_fwd(m.rs2, m.rs2d));
        chk("ex_store_data", ex_store_data, model_fwd(m.rs2, m.rs2d));
        chk("ex_alu_control", 32'(ex_alu_control), 32'(m.ac));
        chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(m.op));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        nxt = '0;
        if (rst_n && !flush && !stall_e && id_valid) begin
            nxt.v = 1'b1;     nxt.pc = id_pc;       nxt.rs1d = id_rs1_data;
            nxt.rs2d = id_rs2_data; nxt.imm = id_imm; nxt.rs1 = id_rs1;
            nxt.rs2 = id_rs2; nxt.rd = id_rd;       nxt.ac = id_alu_control;
            nxt.f3 = id_funct3; nxt.op = id_alu_op; nxt.sa = id_src_a_pc;
            nxt.sb = id_src_b_imm; nxt.rw = id_reg_write;
            nxt.mr = id_mem_read;  nxt.mw = id_mem_write;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic id_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic [3:0] ac, input logic [1:0] op, input logic sa,
                            input logic sb, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = ac; id_alu_op = op;
        id_src_a_pc = sa; id_src_b_imm = sb; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_pc = 32'h0000_0100; id_funct3 = 3'd0;
    endtask

    task automatic producers(input logic mw_en, input logic [4:0] mrd, input logic [31:0] mres,
                             input logic ww_en, input logic [4:0] wrd, input logic [31:0] wres);
        mem_reg_write = mw_en; mem_rd = mrd; mem_result = mres;
        wb_reg_write = ww_en; wb_rd = wrd; wb_result = wres;
    endtask

    initial begin
        m = '0;
        rst_n = 1'b0;
        flush = 1'b0;
        id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0, 0);
        producers(0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_id_stall", 32'(id_stall), 32'd0);
        chk("reset_alu_ctrl", 32'(ex_alu_control), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // add x3,x1,x2
        id_instr(1, 1, 2, 3, 1, 1, 32'd5, 32'd7, 0, 4'b0000, 2'b10, 0, 0, 1, 0, 0);
        cycle();
        id_valid = 1'b0;
        #1;
        chk("add_ex_a", ex_a, 32'd5);
        chk("add_ex_b", ex_b, 32'd7);
        chk("add_alu_ctrl", 32'(ex_alu_control), 32'd0);
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        cycle();

        // consumer of x3 with MEM and WB producers
        id_instr(1, 3, 0, 9, 1, 0, 32'h99, 0, 0, 4'b0000, 2'b10, 0, 1, 1, 0, 0);
        cycle();
        id_valid = 1'b0;
        producers(1, 3, 32'h20, 1, 3, 32'h10);
        #1;
        chk("fwd_mem_prio", ex_a, FWD_EN ? 32'h20 : 32'h99);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", ex_a, FWD_EN ? 32'h10 : 32'h99);
        cycle();
        producers(0, 0, 0, 0, 0, 0);
        cycle();

        // lw x5 then sub x6,x5,x4
        id_instr(1, 0, 0, 5, 0, 0, 0, 0, 32'h40, 4'b0000, 2'b00, 0, 1, 1, 1, 0);
        cycle();
        id_instr(1, 5, 4, 6, 1, 1, 32'hAAA, 32'd4, 0, 4'b0001, 2'b10, 0, 0, 1, 0, 0);
        #1;
        chk("lu_stall", 32'(id_stall), 32'd1);
        cycle();
        producers(1, 5, 32'h100, 0, 0, 0);
        #1;
        chk("lu_bubble_op", 32'(ex_alu_op), 32'd0);
        chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        chk("lu_stall_next", 32'(id_stall), FWD_EN ? 32'd0 : 32'd1);
        cycle();
        producers(0, 0, 0, 1, 5, 32'h55);
        #1;
        chk("lu_wb_fwd", ex_a, FWD_EN ? 32'h55 : 32'd0);
        cycle();
        id_valid = 1'b0;
        producers(0, 0, 0, 0, 0, 0);
        cycle();

        // x0 never forwards
        id_instr(1, 0, 0, 10, 1, 0, 0, 0, 0, 4'b0000, 2'b10, 0, 1, 1, 0, 0);
        producers(1, 0, 32'hFFFF, 0, 0, 0);
        cycle();
        id_valid = 1'b0;
        #1;
        chk("x0_no_fwd", ex_a, 32'd0);
        cycle();
        producers(0, 0, 0, 0, 0, 0);

        // flush kills a branch
        id_instr(1, 1, 2, 0, 1, 1, 32'd1, 32'd2, 32'd8, 4'b0001, 2'b01, 0, 0, 0, 0, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_alu_op", 32'(ex_alu_op), 32'd0);
        cycle();

        // addi x7 then add x8,x7,x7 with the writer walking through MEM and WB
        id_instr(1, 0, 0, 7, 0, 0, 0, 0, 32'h77, 4'b0000, 2'b11, 0, 1, 1, 0, 0);
        cycle();
        id_instr(1, 7, 7, 8, 1, 1, 32'h1, 32'h1, 0, 4'b0000, 2'b10, 0, 0, 1, 0, 0);
        #1;
        chk("nf_stall1", 32'(id_stall), FWD_EN ? 32'd0 : 32'd1);
        cycle();
        producers(1, 7, 32'h77, 0, 0, 0);
        #1;
        chk("nf_stall2", 32'(id_stall), FWD_EN ? 32'd0 : 32'd1);
        cycle();
        producers(0, 0, 0, 1, 7, 32'h77);
        #1;
        chk("nf_stall3", 32'(id_stall), FWD_EN ? 32'd0 : 32'd1);
        cycle();
        producers(0, 0, 0, 0, 0, 0);
        id_rs1_data = 32'h77;
        id_rs2_data = 32'h77;
        #1;
        chk("nf_stall_done", 32'(id_stall), 32'd0);
        cycle();
        id_valid = 1'b0;
        #1;
        chk("nf_ex_a", ex_a, 32'h77);
        chk("nf_ex_b", ex_b, 32'h77);
        chk("nf_ex_valid", 32'(ex_valid), 32'd1);
        cycle();

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            id_valid       = ($urandom_range(0, 9) != 0);
            id_pc          = $urandom;
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_rd          = 5'($urandom_range(0, 3));
            id_use_rs1     = 1'($urandom_range(0, 1));
            id_use_rs2     = 1'($urandom_range(0, 1));
            id_rs1_data    = $urandom;
            id_rs2_data    = $urandom;
            id_imm         = $urandom;
            id_alu_control = 4'($urandom_range(0, 15));
            id_funct3      = 3'($urandom_range(0, 7));
            id_alu_op      = 2'($urandom_range(0, 3));
            id_src_a_pc    = 1'($urandom_range(0, 1));
            id_src_b_imm   = 1'($urandom_range(0, 1));
            id_reg_write   = 1'($urandom_range(0, 1));
            id_mem_read    = ($urandom_range(0, 2) == 0);
            id_mem_write   = 1'($urandom_range(0, 1));
            producers(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            flush          = ($urandom_range(0, 7) == 0);
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                chk("midreset_valid", 32'(ex_valid), 32'd0);
                chk("midreset_pc", ex_pc, 32'd0);
                chk("midreset_a", ex_a, 32'd0);
                chk("midreset_op", 32'(ex_alu_op), 32'd0);
                m = '0;
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core. Registers decoded operands and control from ID, resolves RAW hazards by operand forwarding from the MEM and WB stages, and generates the load-use stall. Drives operands A/B, ALU control, funct3 and ALU op straight into the execute-stage ALU. Also supplies the store data and the destination/control fields that continue to EX/MEM.

## Interface
- `XLEN`, 32, datapath width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in XLEN: PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data` in XLEN: register file read data.
- `id_imm` in XLEN: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices.
- `id_use_rs1`, `id_use_rs2` in 1: the instruction actually reads rs1/rs2.
- `id_alu_control` in 4, `id_funct3` in 3, `id_alu_op` in 2: ALU controls.
- `id_src_a_pc` in 1: A = PC (AUIPC/JAL) else rs1.
- `id_src_b_imm` in 1: B = imm else rs2.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: stage controls.
- `mem_rd` in 5, `mem_reg_write` in 1, `mem_result` in XLEN: EX/MEM producer.
- `wb_rd` in 5, `wb_reg_write` in 1, `wb_result` in XLEN: MEM/WB producer.
- `flush` in 1: branch/jump redirect; kill the instruction entering ID/EX.
- `id_stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1; `ex_pc` out XLEN; `ex_rd` out 5.
- `ex_a`, `ex_b` out XLEN: ALU operands.
- `ex_alu_control` out 4, `ex_funct3` out 3, `ex_alu_op` out 2: to ALU.
- `ex_store_data` out XLEN: forwarded rs2 value.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1.

## Operation
- Register update, in priority order on each rising edge:
  - `flush`, or `id_stall`, or `!id_valid`: load a bubble.
  - Otherwise: capture every `id_*` field.
- Bubble contents: `valid`, `reg_write`, `mem_read`, `mem_write` = 0; `alu_op` = 2'b00, so no branch condition is raised; `alu_control` = 4'b0000; all data and index fields = 0.
- Forwarding is combinational on the registered rs1/rs2 values, per operand:
  - Take MEM if `mem_reg_write && mem_rd != 0 && mem_rd == rsX`.
  - Else take WB under the same rule using the `wb_*` inputs.
  - Else use the registered value.
  - MEM has priority over WB.
- Output muxes, applied after forwarding:
  - `ex_a` = `src_a_pc` ? `ex_pc` : fwd_rs1.
  - `ex_b` = `src_b_imm` ? imm : fwd_rs2.
  - `ex_store_data` = fwd_rs2, always.
- Load-use: `id_stall` = `id_valid && ex_valid && ex_mem_read && ex_rd != 0` and one of:
  - `id_use_rs1 && id_rs1 == ex_rd`
  - `id_use_rs2 && id_rs2 == ex_rd`
- `id_stall` is combinational and is also asserted together with `flush`. Upstream ignores the stall when it flushes.
- x0 is never a hazard and never a forwarding source.

## Timing
- Latency: 1 cycle from ID capture to EX outputs. Forwarding adds 0 cycles.
- Load-use costs exactly 1 bubble: the dependent instruction enters EX one cycle later and takes the loaded value via WB forwarding.
- Reset: all outputs 0 (`ex_alu_control` = 4'b0000, `ex_alu_op` = 2'b00, `id_stall` = 0). Reset asserted mid-operation clears the register immediately.
- `flush` and `id_stall` in the same cycle: a bubble is loaded. Nothing is captured twice.
- `mem_rd == wb_rd` with both writing: the MEM value wins.

## Configuration
- `ID_EX_FORWARDING_EN` defined (default build):
  - Forwarding as described.
  - Stall on load-use only.
- `ID_EX_FORWARDING_EN` undefined:
  - Operands come only from the registered register file data.
  - `id_stall` asserts on any used rs1/rs2 (≠0) matching the rd of a writing valid instruction in EX, or matching `mem_rd`/`wb_rd` with their reg_write set.
  - Bubbles are inserted until the writer has retired.

## Structure
- Shared package `rv32_pkg` holds:
  - ALU control encodings (ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, AUIPC=1000, LUI=1001, SLL=1010, SRA=1011, SRL=1100).
  - ALU op encodings (01 = branch).
  - Forward-select enum FWD_REG / FWD_MEM / FWD_WB.
  - XLEN.
- One sub-module `operand_forward`:
  - Ports: rs index, registered value, MEM/WB producer fields.
  - Outputs: forwarded value and select.
  - Instantiated once for rs1 and once for rs2.

## Test plan
- Reset, then `add x3,x1,x2` with rs1_data=5, rs2_data=7 → next cycle `ex_a`=5, `ex_b`=7, `ex_alu_control`=0000, `ex_valid`=1.
- Producer in MEM with `mem_rd`=3 and `mem_result`=0x20, and in WB with `wb_rd`=3 and `wb_result`=0x10; consumer reads x3 → `ex_a`=0x20. Remove the MEM producer → `ex_a`=0x10.
- `lw x5` in EX, ID holds `sub x6,x5,x4` → `id_stall`=1 for 1 cycle and a bubble enters (`ex_alu_op`=00, `ex_reg_write`=0). Next cycle the sub sees `ex_a` = `wb_result`.
- `mem_rd`=0 with `mem_result`=0xFFFF and consumer rs1=x0 → `ex_a` = registered 0.
- `flush`=1 while `id_valid`=1 with a branch in ID → next cycle `ex_valid`=0 and `ex_alu_op`=00.
- Build without the macro: `addi x7` in EX, then dependent `add x8,x7,x7` → `id_stall` high for 3 cycles, after which the operands equal the register file data.
